bram_rd_responder: RTL
======================

// Module: bram_rd_responder
// PURPOSE
//  BRAM-side responder for the instruction/data read request interface.
//  Accepts a 4-phase request (RD_START/RD_ADDR) from a clockless click-domain
//  requester, fetches four 32-bit words from a synchronous BRAM port and
//  returns one 128-bit line on RD_DATA, acknowledged by RD_DONE.
//  Sits between the instruction streamer and the BRAM, in the clk domain.
// PARAMETERS
//  BASE_ADDR    32'hC000_0000  byte address mapped to BRAM word 0
//  BRAM_AW      12             BRAM word-address width (depth 2**BRAM_AW x 32b)
//  BRAM_LAT     1              read latency, cycles, address -> bram_dout valid (>=1)
//  SYNC_STAGES  2              flops in the RD_START synchroniser (>=2)
// PORTS
//  clk        in   1         BRAM clock
//  rst        in   1         reset, asynchronous, active-low
//  RD_START   in   1         request level from click domain (async to clk)
//  RD_ADDR    in   32        byte address, stable while RD_START=1
//  RD_DATA    out  128       returned line, first word in [127:96]
//  RD_DONE    out  1         acknowledge level, driven straight from a flop
//  bram_en    out  1         BRAM read enable
//  bram_addr  out  BRAM_AW   BRAM word address
//  bram_dout  in   32        BRAM read data
//  rd_err     out  1         last request was misaligned/out of range
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  Reset: RD_DATA=0, RD_DONE=0, bram_en=0, bram_addr=0, rd_err=0, busy=0,
//   state=IDLE, sync chain=0, armed=0.
//  RD_START passes SYNC_STAGES flops -> start_s. Only start_s is used in FSM;
//   RD_ADDR is sampled only when start_s=1 (already stable by protocol).
//  armed set when start_s seen 0; request accepted only if armed=1, so a
//   START still high out of reset is ignored until it drops.
//  Address check: off = RD_ADDR - BASE_ADDR (32b, modulo). Valid iff
//   off[3:0]==0 and off < 4*2**BRAM_AW. Word addr w0 = off[BRAM_AW+1:2].
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; IDLE -> DONE on error.
//   IDLE : at edge T with start_s=1 & armed: latch w0, clear armed.
//          valid -> ISSUE, rd_err<=0; invalid -> DONE, rd_err<=1, RD_DATA<=0,
//          RD_DONE<=1 at T+1. No BRAM access on error.
//   ISSUE: 4 cycles, bram_en=1, bram_addr=w0+k, k=0..3 (beat counter).
//          Beat k is issued in the cycle after edge T+k.
//   DRAIN: bram_en=0; wait for last beat. A BRAM_LAT-deep valid/beat shift
//          register tags returning data; beat k captured into
//          RD_DATA[127-32k -: 32] at edge T+k+1+BRAM_LAT.
//          RD_DATA updates only via these captures.
//   DONE : RD_DONE<=1 at edge T+5+BRAM_LAT (one edge after last capture, so
//          RD_DATA is stable before RD_DONE rises). Hold until start_s=0,
//          then RD_DONE<=0 next edge, armed<=1, -> IDLE.
//  RD_DATA holds its value until the next request's first capture.
//  RD_DONE never glitches (requester uses its edge as a clock).
//  Reset mid-request: everything returns to reset values immediately;
//   any in-flight BRAM data is discarded (shift register cleared).
//  A START re-asserted while in DONE is not seen until after 0 observed.
// TESTING
//  1. BRAM word i = 32'h1000_0000+i; RD_ADDR=C000_0000, BRAM_LAT=1 ->
//     RD_DATA=1000_0000_1000_0001_1000_0002_1000_0003, RD_DONE at T+6.
//  2. RD_ADDR=C000_0010, BRAM_LAT=3 -> words 4..7, bram_addr 4,5,6,7,
//     RD_DONE at T+8, rd_err=0.
//  3. RD_ADDR=C000_0004 (misaligned) and C000_4000 (BRAM_AW=12, out of
//     range) -> bram_en never 1, RD_DATA=0, rd_err=1, RD_DONE at T+1.
//  4. Last line C000_3FF0 -> words 4092..4095, no wrap; then next valid
//     request clears rd_err.
//  5. Full 4-phase: START held 20 cycles after RD_DONE -> RD_DONE stays 1;
//     START low -> RD_DONE low SYNC_STAGES+1 cycles later; back-to-back
//     request served correctly.
//  6. Assert rst during ISSUE -> all outputs 0 next; START high across reset
//     release -> no request until START goes low and high again.

Source files
------------

// File: rtl/bram_rd_responder.sv
// Serves one 128-bit line per 4-phase RD_START/RD_DONE request by reading four BRAM words.
// Latency: RD_DONE rises 5+BRAM_LAT edges after acceptance (1 edge on an address error).
// Backpressure: RD_DONE is held until the requester drops RD_START; no new request before that.
module bram_rd_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int          BRAM_AW     = 12,
    parameter int          BRAM_LAT    = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RD_START,
    input  logic [31:0]        RD_ADDR,
    output logic [127:0]       RD_DATA,
    output logic               RD_DONE,
    output logic               bram_en,
    output logic [BRAM_AW-1:0] bram_addr,
    input  logic [31:0]        bram_dout,
    output logic               rd_err,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [32:0] LINE_LIMIT = 33'd4 << BRAM_AW;

    logic [1:0]               state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [SYNC_STAGES-1:0]   prime_q, prime_d;
    logic                     armed_q, armed_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     en_q, en_d;
    logic [BRAM_AW-1:0]       addr_q, addr_d;
    logic [127:0]             data_q, data_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [BRAM_LAT-1:0]      sr_vld_q, sr_vld_d;
    logic [BRAM_LAT-1:0][1:0] sr_beat_q, sr_beat_d;

    logic        start_s;
    logic [31:0] off;
    logic        addr_ok;
    logic        cap_vld;
    logic [1:0]  cap_beat;

    assign start_s  = sync_q[SYNC_STAGES-1];
    assign off      = RD_ADDR - BASE_ADDR;
    assign addr_ok  = (off[3:0] == 4'd0) && ({1'b0, off} < LINE_LIMIT);
    assign cap_vld  = sr_vld_q[BRAM_LAT-1];
    assign cap_beat = sr_beat_q[BRAM_LAT-1];

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], RD_START};
        // prime_q marks when start_s reflects a real post-reset sample rather than the cleared chain
        prime_d   = {prime_q[SYNC_STAGES-2:0], 1'b1};
        sr_vld_d  = sr_vld_q;
        sr_beat_d = sr_beat_q;

        sr_vld_d[0]  = en_q;
        sr_beat_d[0] = cnt_q;
        for (int i = 1; i < BRAM_LAT; i++) begin
            sr_vld_d[i]  = sr_vld_q[i-1];
            sr_beat_d[i] = sr_beat_q[i-1];
        end

        if (cap_vld) begin
            case (cap_beat)
                2'd0:    data_d[127:96] = bram_dout;
                2'd1:    data_d[95:64]  = bram_dout;
                2'd2:    data_d[63:32]  = bram_dout;
                default: data_d[31:0]   = bram_dout;
            endcase
        end

        if (prime_q[SYNC_STAGES-1] && !start_s) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s && armed_q) begin
                    armed_d = 1'b0;
                    if (addr_ok) begin
                        addr_d  = off[BRAM_AW+1:2];
                        en_d    = 1'b1;
                        cnt_d   = 2'd0;
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == 2'd3) begin
                    en_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = addr_q + BRAM_AW'(1);
                end
            end
            S_DRAIN: begin
                if (cap_vld && (cap_beat == 2'd3)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // RD_DONE rises one edge after the last capture so RD_DATA is already settled
                if (!done_q) begin
                    done_d = 1'b1;
                end else if (!start_s) begin
                    done_d  = 1'b0;
                    armed_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            prime_q   <= '0;
            armed_q   <= 1'b0;
            cnt_q     <= 2'd0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sr_vld_q  <= '0;
            sr_beat_q <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prime_q   <= prime_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sr_vld_q  <= sr_vld_d;
            sr_beat_q <= sr_beat_d;
        end
    end

    assign RD_DATA   = data_q;
    assign RD_DONE   = done_q;
    assign bram_en   = en_q;
    assign bram_addr = addr_q;
    assign rd_err    = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
